// File: rtl/exc_if.sv
// Signal bundle between the MIPS core and the exception sequencer.
// i_* signals flow from the core into exc_unit; o_* signals flow back to the core.
interface exc_if;
    logic        i_irq;
    logic        i_instr_valid;
    logic        i_illop;
    logic        i_jr_xp;
    logic [31:0] i_pc_plus4;
    logic        o_squash;
    logic        o_xp_we;
    logic [1:0]  o_xp_regdst;
    logic [31:0] o_xp_wdata;
    logic        o_redirect;
    logic [31:0] o_pc_vec;
    logic        o_kernel;
    logic        o_halted;
    logic [15:0] o_trap_cnt;

    modport master (
        output i_irq, i_instr_valid, i_illop, i_jr_xp, i_pc_plus4,
        input  o_squash, o_xp_we, o_xp_regdst, o_xp_wdata, o_redirect,
               o_pc_vec, o_kernel, o_halted, o_trap_cnt
    );

    modport slave (
        input  i_irq, i_instr_valid, i_illop, i_jr_xp, i_pc_plus4,
        output o_squash, o_xp_we, o_xp_regdst, o_xp_wdata, o_redirect,
               o_pc_vec, o_kernel, o_halted, o_trap_cnt
    );
endinterface

// File: rtl/exc_unit.sv
// Exception/interrupt sequencer: squashes the faulting instruction, saves PC+4
// into $XP through the register-file override port and redirects to the handler.
module exc_unit (
    input  logic  clk,
    input  logic  rst_n,
    exc_if.slave  bus
);
    localparam logic [31:0] RESET_VEC = 32'h8000_0000;
    localparam logic [31:0] ILLOP_VEC = 32'h8000_0004;
    localparam logic [31:0] XADR_VEC  = 32'h8000_0008;

    typedef enum logic [2:0] {ST_BOOT, ST_RUN, ST_TRAP, ST_KERN, ST_HALT} state_t;

    state_t      r_state;
    logic        r_irq_meta;
    logic        r_irq_s;
    logic        r_xp_we;
    logic [1:0]  r_xp_regdst;
    logic [31:0] r_xp_wdata;
    logic        r_redirect;
    logic [31:0] r_pc_vec;
    logic        r_kernel;
    logic        r_halted;
    logic [15:0] r_trap_cnt;
    logic        w_squash;
    logic        w_take_trap;

    // irq is asynchronous; a level request stays pending until software clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq_meta <= 1'b0;
            r_irq_s    <= 1'b0;
        end else begin
            r_irq_meta <= bus.i_irq;
            r_irq_s    <= r_irq_meta;
        end
    end

    assign w_take_trap = bus.i_instr_valid & (bus.i_illop | r_irq_s);

    always_comb begin
        w_squash = 1'b0;
        case (r_state)
            ST_RUN:  w_squash = w_take_trap;
            ST_TRAP: w_squash = 1'b1;
            ST_KERN: w_squash = bus.i_instr_valid & bus.i_illop;
            ST_HALT: w_squash = 1'b1;
            default: w_squash = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_BOOT;
            r_xp_we     <= 1'b0;
            r_xp_regdst <= 2'b00;
            r_xp_wdata  <= 32'd0;
            r_redirect  <= 1'b0;
            r_pc_vec    <= RESET_VEC;
            r_kernel    <= 1'b1;
            r_halted    <= 1'b0;
            r_trap_cnt  <= 16'd0;
        end else begin
            // Write and redirect strobes are single-cycle pulses.
            r_xp_we     <= 1'b0;
            r_xp_regdst <= 2'b00;
            r_redirect  <= 1'b0;
            case (r_state)
                ST_BOOT: begin
                    r_redirect <= 1'b1;
                    r_pc_vec   <= RESET_VEC;
                    r_kernel   <= 1'b1;
                    r_state    <= ST_KERN;
                end
                ST_RUN: begin
                    if (w_take_trap) begin
                        r_xp_we     <= 1'b1;
                        r_xp_regdst <= 2'b11;
                        r_xp_wdata  <= bus.i_pc_plus4;
                        r_redirect  <= 1'b1;
                        r_pc_vec    <= bus.i_illop ? ILLOP_VEC : XADR_VEC;
                        r_trap_cnt  <= r_trap_cnt + 16'd1;
                        r_state     <= ST_TRAP;
                    end
                end
                ST_TRAP: begin
                    r_kernel <= 1'b1;
                    r_state  <= ST_KERN;
                end
                ST_KERN: begin
                    // A fault inside the handler is unrecoverable and beats the return.
                    if (bus.i_instr_valid && bus.i_illop) begin
                        r_halted <= 1'b1;
                        r_state  <= ST_HALT;
                    end else if (bus.i_instr_valid && bus.i_jr_xp) begin
                        r_kernel <= 1'b0;
                        r_state  <= ST_RUN;
                    end
                end
                ST_HALT: r_state <= ST_HALT;
                default: r_state <= ST_HALT;
            endcase
        end
    end

    assign bus.o_squash    = w_squash;
    assign bus.o_xp_we     = r_xp_we;
    assign bus.o_xp_regdst = r_xp_regdst;
    assign bus.o_xp_wdata  = r_xp_wdata;
    assign bus.o_redirect  = r_redirect;
    assign bus.o_pc_vec    = r_pc_vec;
    assign bus.o_kernel    = r_kernel;
    assign bus.o_halted    = r_halted;
    assign bus.o_trap_cnt  = r_trap_cnt;
endmodule

// File: tb/tb_exc_unit.sv
// Directed bench for exc_unit: boot, illegal-opcode and interrupt traps,
// kernel masking, double fault and asynchronous reset behaviour.
module tb_exc_unit;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    exc_if bus();

    exc_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end else begin
            $display("ok   %s: %08h", tag, obs);
        end
    endtask

    // Inputs change on the falling edge; outputs are checked 1 ns later.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic ill, input logic jr, input logic [31:0] pc4);
        bus.i_instr_valid = iv;
        bus.i_illop       = ill;
        bus.i_jr_xp       = jr;
        bus.i_pc_plus4    = pc4;
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_squash"},   {31'd0, bus.o_squash},   32'd0);
        check_eq({tag, "_xp_we"},    {31'd0, bus.o_xp_we},    32'd0);
        check_eq({tag, "_redirect"}, {31'd0, bus.o_redirect}, 32'd0);
        check_eq({tag, "_halted"},   {31'd0, bus.o_halted},   32'd0);
        check_eq({tag, "_kernel"},   {31'd0, bus.o_kernel},   32'd1);
        check_eq({tag, "_regdst"},   {30'd0, bus.o_xp_regdst}, 32'd0);
        check_eq({tag, "_wdata"},    bus.o_xp_wdata,          32'd0);
        check_eq({tag, "_pc_vec"},   bus.o_pc_vec,            32'h8000_0000);
        check_eq({tag, "_trap_cnt"}, {16'd0, bus.o_trap_cnt}, 32'd0);
    endtask

    // Release reset and walk BOOT -> KERN -> (jr) -> RUN.
    task automatic boot_to_run(input string tag);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        step();
        check_eq({tag, "_boot_redirect"}, {31'd0, bus.o_redirect}, 32'd1);
        check_eq({tag, "_boot_pc_vec"},   bus.o_pc_vec,            32'h8000_0000);
        drive(1'b1, 1'b0, 1'b1, 32'h8000_0004);
        check_eq({tag, "_jr_no_squash"},  {31'd0, bus.o_squash},   32'd0);
        step();
        check_eq({tag, "_run_kernel"},    {31'd0, bus.o_kernel},   32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus.i_irq = 1'b0;
        bus.i_instr_valid = 1'b0;
        bus.i_illop = 1'b0;
        bus.i_jr_xp = 1'b0;
        bus.i_pc_plus4 = 32'd0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_vals("rst");

        boot_to_run("b1");

        // RUN with instr_valid low: nothing happens even with illop high.
        drive(1'b0, 1'b1, 1'b0, 32'h0000_00F0);
        check_eq("noval_squash", {31'd0, bus.o_squash}, 32'd0);
        step();
        check_eq("noval_redirect", {31'd0, bus.o_redirect}, 32'd0);

        // Illegal opcode in RUN.
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0104);
        check_eq("ill_squash", {31'd0, bus.o_squash}, 32'd1);
        step();
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        check_eq("ill_xp_we",    {31'd0, bus.o_xp_we},     32'd1);
        check_eq("ill_regdst",   {30'd0, bus.o_xp_regdst}, 32'd3);
        check_eq("ill_wdata",    bus.o_xp_wdata,           32'h0000_0104);
        check_eq("ill_redirect", {31'd0, bus.o_redirect},  32'd1);
        check_eq("ill_pc_vec",   bus.o_pc_vec,             32'h8000_0004);
        check_eq("ill_trap_cnt", {16'd0, bus.o_trap_cnt},  32'd1);
        check_eq("ill_trap_sq",  {31'd0, bus.o_squash},    32'd1);
        check_eq("ill_trap_kern",{31'd0, bus.o_kernel},    32'd0);
        step();
        check_eq("ill_kern",     {31'd0, bus.o_kernel},    32'd1);
        check_eq("ill_we_drop",  {31'd0, bus.o_xp_we},     32'd0);
        check_eq("ill_regdst0",  {30'd0, bus.o_xp_regdst}, 32'd0);

        // Return to RUN, then an interrupt goes through the 2-flop synchroniser.
        drive(1'b1, 1'b0, 1'b1, 32'd0);
        step();
        check_eq("ret_kernel", {31'd0, bus.o_kernel}, 32'd0);
        bus.i_irq = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 32'h0000_0200);
        check_eq("irq_lat0", {31'd0, bus.o_squash}, 32'd0);
        step();
        check_eq("irq_lat1", {31'd0, bus.o_squash}, 32'd0);
        step();
        check_eq("irq_squash", {31'd0, bus.o_squash}, 32'd1);
        step();
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        check_eq("irq_pc_vec",   bus.o_pc_vec,            32'h8000_0008);
        check_eq("irq_wdata",    bus.o_xp_wdata,          32'h0000_0200);
        check_eq("irq_trap_cnt", {16'd0, bus.o_trap_cnt}, 32'd2);
        step();

        // irq stays high in KERN: masked for 20 cycles.
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h8000_0010 + 32'(i * 4));
            check_eq($sformatf("kmask_sq%0d", i),  {31'd0, bus.o_squash},   32'd0);
            check_eq($sformatf("kmask_rd%0d", i),  {31'd0, bus.o_redirect}, 32'd0);
            step();
        end
        drive(1'b1, 1'b0, 1'b1, 32'd0);
        check_eq("kjr_no_squash", {31'd0, bus.o_squash}, 32'd0);
        step();
        drive(1'b1, 1'b0, 1'b0, 32'h0000_0300);
        check_eq("b2b_squash", {31'd0, bus.o_squash}, 32'd1);
        step();
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        check_eq("b2b_pc_vec",   bus.o_pc_vec,            32'h8000_0008);
        check_eq("b2b_wdata",    bus.o_xp_wdata,          32'h0000_0300);
        check_eq("b2b_trap_cnt", {16'd0, bus.o_trap_cnt}, 32'd3);
        step();

        // illop and irq together in RUN: ILLOP cause wins.
        drive(1'b1, 1'b0, 1'b1, 32'd0);
        step();
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0400);
        check_eq("both_squash", {31'd0, bus.o_squash}, 32'd1);
        step();
        bus.i_irq = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        check_eq("both_pc_vec",   bus.o_pc_vec,            32'h8000_0004);
        check_eq("both_wdata",    bus.o_xp_wdata,          32'h0000_0400);
        check_eq("both_trap_cnt", {16'd0, bus.o_trap_cnt}, 32'd4);
        step();

        // Double fault: illop and jr_xp in the same KERN cycle -> HALT.
        drive(1'b1, 1'b1, 1'b1, 32'd0);
        check_eq("dbl_squash", {31'd0, bus.o_squash}, 32'd1);
        step();
        drive(1'b1, 1'b0, 1'b1, 32'd0);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("halt_h%0d", i),  {31'd0, bus.o_halted},   32'd1);
            check_eq($sformatf("halt_sq%0d", i), {31'd0, bus.o_squash},   32'd1);
            check_eq($sformatf("halt_rd%0d", i), {31'd0, bus.o_redirect}, 32'd0);
            step();
        end
        check_eq("halt_kernel", {31'd0, bus.o_kernel}, 32'd1);

        // Asynchronous reset from HALT.
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        rst_n = 1'b0;
        #1;
        check_reset_vals("rst2");

        // Reset during TRAP aborts the write at once.
        boot_to_run("b2");
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0504);
        step();
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        check_eq("t2_xp_we",    {31'd0, bus.o_xp_we},    32'd1);
        check_eq("t2_trap_cnt", {16'd0, bus.o_trap_cnt}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("abort_xp_we",    {31'd0, bus.o_xp_we},    32'd0);
        check_eq("abort_redirect", {31'd0, bus.o_redirect}, 32'd0);
        check_eq("abort_trap_cnt", {16'd0, bus.o_trap_cnt}, 32'd0);
        check_eq("abort_pc_vec",   bus.o_pc_vec,            32'h8000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
